wb_slave_model: RTL and testbench

Synthesizable Wishbone classic-cycle slave: a byte-enabled register bank with programmable wait states and an error response for out-of-range addresses.
- Forms the responder end of the bus driven by the team's Wishbone master model.
- Used as a bus target in SPI and core testbenches, and as a reference slave for protocol checks.
- One transfer per strobe assertion; tolerates a master that holds cyc/stb for extra cycles after ack.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_slave_regbank.sv | 26 ++
 rtl/wb_slave_model.sv | 98 +++++++++
 tb/tb_wb_slave_model.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM encoding and lane-count helper for the Wishbone slave model.
package wb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/wb_slave_regbank.sv
// wb_slave_regbank: byte-enabled register array with sync reset-to-zero and combinational read.
module wb_slave_regbank
  import wb_pkg::*;
#(
  parameter int dwidth     = 32,
  parameter int depth_log2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [depth_log2-1:0]     idx_i,
  input  logic [lanes(dwidth)-1:0]  sel_i,
  input  logic [dwidth-1:0]         din_i,
  output logic [dwidth-1:0]         dout_o
);
  logic [dwidth-1:0] mem_q [2**depth_log2];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**depth_log2; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < lanes(dwidth); b++)
        if (sel_i[b]) mem_q[idx_i][8*b +: 8] <= din_i[8*b +: 8];
    end
  end
  assign dout_o = mem_q[idx_i];
endmodule

// File: rtl/wb_slave_model.sv
// wb_slave_model: Wishbone classic slave with wait states and err on out-of-range addresses.
// Optional WB_SLAVE_RETRY_EN: every retry_every-th request is terminated with rty.
module wb_slave_model
  import wb_pkg::*;
#(
  parameter int dwidth      = 32,
  parameter int awidth      = 32,
  parameter int depth_log2  = 4,
  parameter int wait_states = 1,
  parameter int retry_every = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [awidth-1:0]        adr,
  input  logic [dwidth-1:0]        din,
  output logic [dwidth-1:0]        dout,
  input  logic                     cyc,
  input  logic                     stb,
  input  logic                     we,
  input  logic [lanes(dwidth)-1:0] sel,
  output logic                     ack,
  output logic                     err,
  output logic                     rty
);
  state_t            state_q;
  logic [3:0]        wcnt_q;
  logic              ack_q, err_q, rty_q;
  logic [dwidth-1:0] dout_q, rdata;
  logic              in_range, req, fire, retry_slot, wr_en;
  logic              unused_adr;
  assign unused_adr = ^adr[1:0];
  assign in_range = adr[awidth-1:depth_log2+2] == '0;
  assign req = cyc & stb;
  assign fire = state_q == RESP;
`ifdef WB_SLAVE_RETRY_EN
  localparam int RW = $clog2(retry_every + 1);
  logic [RW-1:0] rcnt_q, rcnt_d;
  assign rcnt_d = rcnt_q + 1'b1;
  assign retry_slot = fire && rcnt_d == RW'(retry_every);
  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else if (fire) rcnt_q <= retry_slot ? '0 : rcnt_d;
  end
`else
  localparam int unused_retry_every = retry_every;
  assign retry_slot = 1'b0;
`endif
  assign wr_en = fire & in_range & we & ~retry_slot;
  wb_slave_regbank #(.dwidth(dwidth), .depth_log2(depth_log2)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en),
    .idx_i  (adr[depth_log2+1:2]),
    .sel_i  (sel),
    .din_i  (din),
    .dout_o (rdata)
  );
  // Outputs default low every cycle so any termination lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rty_q  <= 1'b0;
      dout_q <= '0;
      case (state_q)
        IDLE: if (req) begin
          wcnt_q  <= 4'(wait_states);
          state_q <= (wait_states == 0) ? RESP : WAIT;
        end
        WAIT: if (!req) state_q <= IDLE;
        else begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          rty_q   <= retry_slot;
          err_q   <= ~retry_slot & ~in_range;
          ack_q   <= ~retry_slot & in_range;
          dout_q  <= (~retry_slot & in_range & ~we) ? rdata : '0;
          state_q <= HOLD;
        end
        HOLD: if (!req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack  = ack_q;
  assign err  = err_q;
  assign rty  = rty_q;
  assign dout = dout_q;
endmodule

// File: tb/tb_wb_slave_model.sv
// tb_wb_slave_model: directed Wishbone transfers with a queue-based response scoreboard.
module tb_wb_slave_model;
  localparam int WS = 1;
  localparam int RE = 4;
  localparam logic [1:0] K_ACK = 2'd0, K_ERR = 2'd1, K_RTY = 2'd2;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, din = '0, dout;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic        ack, err, rty;
  int          compared = 0, mismatched = 0, n_term = 0, t0;
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
    bit          chk;
  } exp_t;
  exp_t        sb[$];
  exp_t        me;
  logic [1:0]  mk;

  always #5 clk = ~clk;

  wb_slave_model #(
    .dwidth(32), .awidth(32), .depth_log2(4), .wait_states(WS), .retry_every(RE)
  ) dut (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout), .cyc(cyc), .stb(stb),
    .we(we), .sel(sel), .ack(ack), .err(err), .rty(rty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (!ack) check("dout_idle", dout, 32'h0);
    if (ack | err | rty) begin
      n_term++;
      mk = ack ? K_ACK : err ? K_ERR : K_RTY;
      check("exclusive", 32'(ack) + 32'(err) + 32'(rty), 32'd1);
      if (sb.size() == 0) check("unexpected_term", {30'b0, mk}, 32'd3);
      else begin
        me = sb.pop_front();
        check("term_kind", {30'b0, mk}, {30'b0, me.kind});
        if (me.chk) check("term_data", dout, me.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rty", {31'b0, rty}, 32'h0);
    check("rst_dout", dout, 32'h0);
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] k, input logic [31:0] ed, input bit c);
    int lat;
    lat = 0;
    sb.push_back('{kind: k, data: ed, chk: c});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; din = d; sel = s;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(ack | err | rty) && lat < 30);
    check("latency", lat, WS + 2);
    if (!(ack | err | rty)) void'(sb.pop_back());
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] k);
    xfer(1'b1, a, d, s, k, 32'h0, k != K_ACK);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] k, input logic [31:0] ed);
    xfer(1'b0, a, 32'h0, 4'hF, k, ed, 1'b1);
  endtask

  initial begin
    do_reset();
`ifdef WB_SLAVE_RETRY_EN
    wr(32'h10, 32'h1, 4'hF, K_ACK);
    wr(32'h14, 32'h2, 4'hF, K_ACK);
    wr(32'h18, 32'h3, 4'hF, K_ACK);
    wr(32'h1C, 32'h4, 4'hF, K_RTY);
    wr(32'h20, 32'h5, 4'hF, K_ACK);
    rd(32'h1C, K_ACK, 32'h0);
    rd(32'h20, K_ACK, 32'h5);
    rd(32'h10, K_RTY, 32'h0);
    rd(32'h10, K_ACK, 32'h1);
    rd(32'h14, K_ACK, 32'h2);
    rd(32'h18, K_ACK, 32'h3);
    rd(32'h40, K_RTY, 32'h0);
    rd(32'h40, K_ERR, 32'h0);
`else
    wr(32'h08, 32'hDEADBEEF, 4'hF, K_ACK);
    rd(32'h08, K_ACK, 32'hDEADBEEF);
    wr(32'h00, 32'h11223344, 4'hF, K_ACK);
    wr(32'h00, 32'hAABBCCDD, 4'h5, K_ACK);
    rd(32'h00, K_ACK, 32'h11BB33DD);
    wr(32'h40, 32'hFFFFFFFF, 4'hF, K_ERR);
    rd(32'h00, K_ACK, 32'h11BB33DD);
    rd(32'h44, K_ERR, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0C; din = 32'h12345678; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (6) @(posedge clk);
    rd(32'h0C, K_ACK, 32'h0);
    wr(32'h0C, 32'h12345678, 4'hF, K_ACK);
    rd(32'h0C, K_ACK, 32'h12345678);
    t0 = n_term;
    wr(32'h3C, 32'hFFFFFFFF, 4'h0, K_ACK);
    rd(32'h3C, K_ACK, 32'h0);
    wr(32'h3C, 32'hA5000000, 4'h8, K_ACK);
    rd(32'h3F, K_ACK, 32'hA5000000);
    check("four_terms", n_term - t0, 32'd4);
`endif
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h08; din = 32'hCAFEF00D; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("rst_wait_term", {29'b0, ack, err, rty}, 32'h0);
    repeat (4) @(posedge clk);
    rd(32'h08, K_ACK, 32'h0);
    rd(32'h10, K_ACK, 32'h0);
    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
